ps2_host_tx: RTL

Host-to-device PS/2 transmitter. Sends single command bytes to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset. It is the opposite direction to the existing keyboard receive path. It runs on pixelClk and drives the shared PS/2 clock and data lines as open-drain. The receive controller gates itself off with txBusy while a transfer is in progress.

---
 rtl/ps2_host_tx.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibits the bus, requests to send, then shifts
// one byte, odd parity and stop on device clock edges and checks the device ack.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 3000,
    parameter int START_TIMEOUT  = 375000,
    parameter int PACKET_TIMEOUT = 50000,
    parameter int FILTER_CYCLES  = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] txByte,
    input  logic       txStart,
    input  logic       ps2ClkIn,
    input  logic       ps2DataIn,
    output logic       ps2ClkOe,
    output logic       ps2DataOe,
    output logic       txBusy,
    output logic       txDone,
    output logic       txError,
    output logic [1:0] errCode
);

    localparam int WAIT_MAX = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int PKT_W    = $clog2(PACKET_TIMEOUT + 1);
    localparam int FLT_W    = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE, INHIBIT, REQ, WAIT_CLK, SHIFT, ACK, WAIT_IDLE, ERR
    } stateT;

    stateT             state;
    logic [1:0]        clkSync;
    logic [1:0]        dataSync;
    logic              clkFilt;
    logic              dataFilt;
    logic              clkPrev;
    logic [FLT_W-1:0]  clkCnt;
    logic [FLT_W-1:0]  dataCnt;
    logic              fallStrobe;
    logic [7:0]        txData;
    logic              parityBit;
    logic [3:0]        bitIdx;
    logic [WAIT_W-1:0] waitCnt;
    logic [PKT_W-1:0]  pktCnt;

    function automatic logic oddParity(input logic [7:0] b);
        return ~^b;
    endfunction

    function automatic logic [WAIT_W-1:0] incWait(input logic [WAIT_W-1:0] c);
        return (&c) ? c : c + WAIT_W'(1);
    endfunction

    function automatic logic [PKT_W-1:0] incPkt(input logic [PKT_W-1:0] c);
        return (&c) ? c : c + PKT_W'(1);
    endfunction

    // cnt is the number of cycles already elapsed before the current one
    function automatic logic timeUp(input int cnt, input int limit);
        return (cnt + 1) >= limit;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clkSync  <= 2'b11;
            dataSync <= 2'b11;
        end else begin
            clkSync  <= {clkSync[0], ps2ClkIn};
            dataSync <= {dataSync[0], ps2DataIn};
        end
    end

    // A filtered level only follows the synchronized line after FILTER_CYCLES differing samples
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clkFilt <= 1'b1;
            clkPrev <= 1'b1;
            clkCnt  <= '0;
        end else begin
            clkPrev <= clkFilt;
            if (clkSync[1] == clkFilt) begin
                clkCnt <= '0;
            end else if (clkCnt == FLT_W'(FILTER_CYCLES - 1)) begin
                clkFilt <= clkSync[1];
                clkCnt  <= '0;
            end else begin
                clkCnt <= clkCnt + FLT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dataFilt <= 1'b1;
            dataCnt  <= '0;
        end else begin
            if (dataSync[1] == dataFilt) begin
                dataCnt <= '0;
            end else if (dataCnt == FLT_W'(FILTER_CYCLES - 1)) begin
                dataFilt <= dataSync[1];
                dataCnt  <= '0;
            end else begin
                dataCnt <= dataCnt + FLT_W'(1);
            end
        end
    end

    assign fallStrobe = clkPrev & ~clkFilt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ps2ClkOe  <= 1'b0;
            ps2DataOe <= 1'b0;
            txBusy    <= 1'b0;
            txDone    <= 1'b0;
            txError   <= 1'b0;
            errCode   <= 2'b00;
            txData    <= '0;
            parityBit <= 1'b0;
            bitIdx    <= '0;
            waitCnt   <= '0;
            pktCnt    <= '0;
        end else begin
            txDone  <= 1'b0;
            txError <= 1'b0;
            case (state)
                IDLE: begin
                    // a start landing on the txDone cycle is dropped so the two never coincide
                    if (txStart && !txDone) begin
                        txData    <= txByte;
                        parityBit <= oddParity(txByte);
                        errCode   <= 2'b00;
                        waitCnt   <= '0;
                        ps2ClkOe  <= 1'b1;
                        txBusy    <= 1'b1;
                        state     <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (timeUp(int'(waitCnt), INHIBIT_CYCLES)) begin
                        waitCnt   <= '0;
                        ps2DataOe <= 1'b1;
                        state     <= REQ;
                    end else begin
                        waitCnt <= incWait(waitCnt);
                    end
                end
                REQ: begin
                    if (waitCnt == WAIT_W'(1)) begin
                        waitCnt  <= '0;
                        ps2ClkOe <= 1'b0;
                        state    <= WAIT_CLK;
                    end else begin
                        waitCnt <= incWait(waitCnt);
                    end
                end
                WAIT_CLK: begin
                    if (timeUp(int'(waitCnt), START_TIMEOUT)) begin
                        ps2ClkOe  <= 1'b0;
                        ps2DataOe <= 1'b0;
                        txError   <= 1'b1;
                        errCode   <= 2'b01;
                        state     <= ERR;
                    end else if (fallStrobe) begin
                        ps2DataOe <= ~txData[0];
                        bitIdx    <= 4'd1;
                        pktCnt    <= PKT_W'(1);
                        state     <= SHIFT;
                    end else begin
                        waitCnt <= incWait(waitCnt);
                    end
                end
                SHIFT: begin
                    if (timeUp(int'(pktCnt), PACKET_TIMEOUT)) begin
                        ps2ClkOe  <= 1'b0;
                        ps2DataOe <= 1'b0;
                        txError   <= 1'b1;
                        errCode   <= 2'b10;
                        state     <= ERR;
                    end else begin
                        pktCnt <= incPkt(pktCnt);
                        if (fallStrobe) begin
                            bitIdx <= bitIdx + 4'd1;
                            if (bitIdx <= 4'd7) begin
                                ps2DataOe <= ~txData[bitIdx[2:0]];
                            end else if (bitIdx == 4'd8) begin
                                ps2DataOe <= ~parityBit;
                            end else begin
                                ps2DataOe <= 1'b0;
                                state     <= ACK;
                            end
                        end
                    end
                end
                ACK: begin
                    if (timeUp(int'(pktCnt), PACKET_TIMEOUT)) begin
                        ps2ClkOe  <= 1'b0;
                        ps2DataOe <= 1'b0;
                        txError   <= 1'b1;
                        errCode   <= 2'b10;
                        state     <= ERR;
                    end else begin
                        pktCnt <= incPkt(pktCnt);
                        if (fallStrobe) begin
                            if (!dataFilt) begin
                                state <= WAIT_IDLE;
                            end else begin
                                ps2ClkOe  <= 1'b0;
                                ps2DataOe <= 1'b0;
                                txError   <= 1'b1;
                                errCode   <= 2'b11;
                                state     <= ERR;
                            end
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (clkFilt && dataFilt) begin
                        txDone <= 1'b1;
                        txBusy <= 1'b0;
                        state  <= IDLE;
                    end
                end
                ERR: begin
                    txBusy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    ps2ClkOe  <= 1'b0;
                    ps2DataOe <= 1'b0;
                    txBusy    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
